// File: rtl/uart_tx_word_serializer_if.sv
// Word-in / byte-out bundle for uart_tx_word_serializer.
// master: word producer plus UART_TX busy feedback (drives word_in, word_valid, tx_busy).
// slave:  the serializer itself.
interface uart_tx_word_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] word_in;
  logic                  word_valid;
  logic                  word_ready;
  logic                  tx_busy;
  logic [7:0]            tx_byte;
  logic                  tx_byte_valid;
  logic [CNT_W-1:0]      fifo_count;
  logic                  overflow;
  logic                  idle;

  modport master (
    output word_in, word_valid, tx_busy,
    input  word_ready, tx_byte, tx_byte_valid, fifo_count, overflow, idle
  );

  modport slave (
    input  word_in, word_valid, tx_busy,
    output word_ready, tx_byte, tx_byte_valid, fifo_count, overflow, idle
  );
endinterface

// File: rtl/uart_tx_word_serializer.sv
// uart_tx_word_serializer: buffers DATA_WIDTH-bit words in a small FIFO and feeds them
// to UART_TX one byte per frame, LSB byte first, pacing on UART_TX's busy signal.
// A byte whose pulse is not acknowledged by busy within ACK_TIMEOUT cycles is re-sent.
// Optional feature macro: SERIALIZER_CHECKSUM_EN -- appends an XOR-of-bytes frame per word.
module uart_tx_word_serializer #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  uart_tx_word_serializer_if.slave bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TMR_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  // Word FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic                  word_ready_int;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_word;

  // Serializer state
  state_t                state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [IDX_W-1:0]      byte_idx_reg;
  logic [TMR_W-1:0]      retry_reg;
  logic [7:0]            tx_byte_reg;
  logic                  overflow_reg;

`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0]            head_csum;
  logic [7:0]            csum_reg;
  logic                  csum_phase_reg;
`endif

  // Ready is forced low during reset so nothing is accepted while the FIFO is cleared.
  assign word_ready_int = rst_n && (count_reg < CNT_W'(FIFO_DEPTH));
  assign push           = bus.word_valid && word_ready_int;
  assign pop            = (state_reg == S_IDLE) && (count_reg != '0);
  assign head_word      = mem_reg[rd_ptr_reg];
  assign shift_next     = shift_reg >> 8;

  // Occupancy update: simultaneous push and pop cancel out
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

`ifdef SERIALIZER_CHECKSUM_EN
  // XOR of all data bytes of the word about to be popped
  always_comb begin
    head_csum = 8'h00;
    for (int i = 0; i < BYTES; i++) begin
      head_csum = head_csum ^ head_word[8*i +: 8];
    end
  end
`endif

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= bus.word_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  // Sticky flag for any word offered while the FIFO could not take it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (bus.word_valid && !word_ready_int) begin
      overflow_reg <= 1'b1;
    end
  end

  // Byte sequencer: pop a word, pulse each byte, wait for UART_TX to take and finish it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      shift_reg      <= '0;
      byte_idx_reg   <= '0;
      retry_reg      <= '0;
      tx_byte_reg    <= 8'h00;
`ifdef SERIALIZER_CHECKSUM_EN
      csum_reg       <= 8'h00;
      csum_phase_reg <= 1'b0;
`endif
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (pop) begin
            shift_reg    <= head_word;
            tx_byte_reg  <= head_word[7:0];
            byte_idx_reg <= '0;
            state_reg    <= S_SEND;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_reg       <= head_csum;
            csum_phase_reg <= 1'b0;
`endif
          end
        end
        S_SEND: begin
          // The pulse is exactly this one cycle; start the acknowledge window fresh
          retry_reg <= '0;
          state_reg <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // Busy already high here counts as the acknowledge
          if (bus.tx_busy) begin
            state_reg <= S_WAIT_DONE;
          end else if (retry_reg == TMR_W'(ACK_TIMEOUT)) begin
            state_reg <= S_SEND;
          end else begin
            retry_reg <= retry_reg + TMR_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
`ifdef SERIALIZER_CHECKSUM_EN
            if (csum_phase_reg) begin
              state_reg <= S_IDLE;
            end else if (byte_idx_reg < IDX_W'(BYTES - 1)) begin
              shift_reg    <= shift_next;
              tx_byte_reg  <= shift_next[7:0];
              byte_idx_reg <= byte_idx_reg + IDX_W'(1);
              state_reg    <= S_SEND;
            end else begin
              csum_phase_reg <= 1'b1;
              tx_byte_reg    <= csum_reg;
              state_reg      <= S_SEND;
            end
`else
            if (byte_idx_reg < IDX_W'(BYTES - 1)) begin
              shift_reg    <= shift_next;
              tx_byte_reg  <= shift_next[7:0];
              byte_idx_reg <= byte_idx_reg + IDX_W'(1);
              state_reg    <= S_SEND;
            end else begin
              state_reg <= S_IDLE;
            end
`endif
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.word_ready    = word_ready_int;
  assign bus.tx_byte       = tx_byte_reg;
  assign bus.tx_byte_valid = (state_reg == S_SEND);
  assign bus.fifo_count    = count_reg;
  assign bus.overflow      = overflow_reg;
  assign bus.idle          = !rst_n || ((state_reg == S_IDLE) && (count_reg == '0));

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Testbench for uart_tx_word_serializer: transaction-level reference model checked
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_word_serializer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int ACK   = 16;
  localparam int BYTES = DW / 8;
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int FRAMES = BYTES + 1;
`else
  localparam int FRAMES = BYTES;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int neg_cnt  = 0;
  int push_neg = 0;

  logic [7:0] pulse_bytes[$];
  int         pulse_negs[$];

  // Reference model state: words waiting, frames of the word in service, pulse/ack phase
  logic [DW-1:0] m_fifo[$];
  logic [7:0]    m_frames[$];
  bit            m_active   = 1'b0;
  bit            m_show     = 1'b0;
  bit            m_ack_wait = 1'b0;
  int            m_age      = 0;
  logic [7:0]    m_tx_byte  = 8'h00;
  bit            m_overflow = 1'b0;

  // UART_TX busy emulation: 0 = normal, 1 = stalled high, 2 = never busy
  int busy_mode  = 0;
  int busy_left  = 0;
  int busy_len   = 10;
  bit uart_pulse = 1'b0;

  always #5 clk = ~clk;

  uart_tx_word_serializer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_word_serializer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Frame k of a word: data bytes LSB first, then (optionally) the XOR of all data bytes
  function automatic logic [7:0] frame_byte(input logic [DW-1:0] w, input int k);
    logic [7:0] x;
    x = 8'h00;
    if (k < BYTES) return w[8*k +: 8];
    for (int i = 0; i < BYTES; i++) x = x ^ w[8*i +: 8];
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees at that edge
  task automatic model_step();
    int            sz;
    bit            push_ok;
    logic [DW-1:0] w;
    if (!rst_n) begin
      m_fifo.delete();
      m_frames.delete();
      m_active   = 1'b0;
      m_show     = 1'b0;
      m_ack_wait = 1'b0;
      m_age      = 0;
      m_tx_byte  = 8'h00;
      m_overflow = 1'b0;
      return;
    end
    sz      = m_fifo.size();
    push_ok = bus.word_valid && (sz < DEPTH);
    if (bus.word_valid && !push_ok) m_overflow = 1'b1;
    if (!m_active) begin
      if (sz > 0) begin
        w = m_fifo.pop_front();
        m_frames.delete();
        for (int k = 0; k < FRAMES; k++) m_frames.push_back(frame_byte(w, k));
        m_active  = 1'b1;
        m_show    = 1'b1;
        m_tx_byte = m_frames[0];
      end
    end else if (m_show) begin
      m_show     = 1'b0;
      m_ack_wait = 1'b1;
      m_age      = 0;
    end else if (m_ack_wait) begin
      if (bus.tx_busy) begin
        m_ack_wait = 1'b0;
      end else if (m_age == ACK) begin
        m_ack_wait = 1'b0;
        m_show     = 1'b1;
      end else begin
        m_age++;
      end
    end else if (!bus.tx_busy) begin
      void'(m_frames.pop_front());
      if (m_frames.size() > 0) begin
        m_show    = 1'b1;
        m_tx_byte = m_frames[0];
      end else begin
        m_active = 1'b0;
      end
    end
    if (push_ok) m_fifo.push_back(bus.word_in);
  endtask

  // Model process
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare process: all outputs against the model on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (bus.tx_byte_valid === 1'b1) begin
        pulse_bytes.push_back(bus.tx_byte);
        pulse_negs.push_back(neg_cnt);
      end
      chk("tx_byte_valid", 32'(bus.tx_byte_valid), 32'(m_show));
      chk("tx_byte", 32'(bus.tx_byte), 32'(m_tx_byte));
      chk("fifo_count", 32'(bus.fifo_count), 32'(m_fifo.size()));
      chk("word_ready", 32'(bus.word_ready), 32'(rst_n && (m_fifo.size() < DEPTH)));
      chk("idle", 32'(bus.idle), 32'(!rst_n || (!m_active && m_fifo.size() == 0)));
      chk("overflow", 32'(bus.overflow), 32'(m_overflow));
    end
  end

  // UART_TX busy emulation
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      uart_pulse = bus.tx_byte_valid;
      @(posedge clk);
      #1;
      case (busy_mode)
        0: begin
          if (uart_pulse) busy_left = busy_len;
          bus.tx_busy = (busy_left > 0);
          if (busy_left > 0) busy_left--;
        end
        1:       bus.tx_busy = 1'b1;
        default: bus.tx_busy = 1'b0;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    bus.word_valid = 1'b1;
    bus.word_in    = w;
    tick(1);
    push_neg       = neg_cnt;
    bus.word_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    tick(1);
    while (!bus.idle && i < budget) begin
      tick(1);
      i++;
    end
    if (!bus.idle) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout actual=busy required=idle t=%0t", $time);
    end
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int i;
    i = 0;
    while (pulse_bytes.size() < n && i < budget) begin
      tick(1);
      i++;
    end
    if (pulse_bytes.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_pulses timeout actual=%0d required=%0d", pulse_bytes.size(), n);
    end
  endtask

  task automatic release_busy();
    busy_mode = 0;
    busy_left = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int            base;
    int            n;
    int            guard;
    logic [DW-1:0] sent[$];
    logic [DW-1:0] w;

    bus.word_valid = 1'b0;
    bus.word_in    = '0;

    // Reset values
    tick(3);
    chk("rst word_ready", 32'(bus.word_ready), 32'd0);
    chk("rst idle", 32'(bus.idle), 32'd1);
    chk("rst fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst tx_byte_valid", 32'(bus.tx_byte_valid), 32'd0);
    chk("rst overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("post-rst word_ready", 32'(bus.word_ready), 32'd1);

    // Single word, byte order and first-pulse latency
    $display("T1 single word 44332211");
    base = pulse_bytes.size();
    push(32'h44332211);
    wait_idle(400);
    chk("t1 frames", 32'(pulse_bytes.size() - base), 32'(FRAMES));
    chk("t1 byte0", 32'(pulse_bytes[base + 0]), 32'h11);
    chk("t1 byte1", 32'(pulse_bytes[base + 1]), 32'h22);
    chk("t1 byte2", 32'(pulse_bytes[base + 2]), 32'h33);
    chk("t1 byte3", 32'(pulse_bytes[base + 3]), 32'h44);
    chk("t1 latency", 32'(pulse_negs[base] - push_neg), 32'd2);
    chk("t1 idle", 32'(bus.idle), 32'd1);

    // Stalled UART: FIFO fills, fifth queued push overflows
    $display("T2 stalled UART fill");
    busy_mode = 1;
    base = pulse_bytes.size();
    push(32'hA0A0A0A0);
    tick(3);
    for (int i = 0; i < 5; i++) push(32'hB0000000 + 32'(i));
    chk("t2 fifo_count", 32'(bus.fifo_count), 32'd4);
    chk("t2 word_ready", 32'(bus.word_ready), 32'd0);
    chk("t2 overflow", 32'(bus.overflow), 32'd1);
    release_busy();
    wait_idle(3000);
    chk("t2 frames", 32'(pulse_bytes.size() - base), 32'(5 * FRAMES));
    chk("t2 overflow sticky", 32'(bus.overflow), 32'd1);

    // UART never acknowledges: same byte re-pulsed every ACK+2 cycles
    $display("T3 no acknowledge retry");
    busy_mode = 2;
    base = pulse_bytes.size();
    w = 32'hCAFE0155;
    push(w);
    wait_pulses(base + 3, 200);
    chk("t3 period a", 32'(pulse_negs[base + 1] - pulse_negs[base]), 32'd18);
    chk("t3 period b", 32'(pulse_negs[base + 2] - pulse_negs[base + 1]), 32'd18);
    chk("t3 retry byte a", 32'(pulse_bytes[base + 1]), 32'h55);
    chk("t3 retry byte b", 32'(pulse_bytes[base + 2]), 32'h55);
    release_busy();
    wait_idle(1000);
    n = pulse_bytes.size();
    for (int k = 1; k < FRAMES; k++) begin
      chk("t3 resumed byte", 32'(pulse_bytes[n - FRAMES + k]), 32'(frame_byte(w, k)));
    end

    // Push and pop on the same edge with two words queued
    $display("T4 push+pop at count 2");
    busy_mode = 1;
    push(32'h0C0C0C0C);
    tick(3);
    push(32'h0D0D0D0D);
    push(32'h0E0E0E0E);
    chk("t4 count before", 32'(bus.fifo_count), 32'd2);
    release_busy();
    guard = 0;
    while (!(!m_active && m_fifo.size() == 2) && guard < 500) begin
      tick(1);
      guard++;
    end
    chk("t4 reached pop point", 32'(guard < 500), 32'd1);
    push(32'h0F0F0F0F);
    chk("t4 count after", 32'(bus.fifo_count), 32'd2);
    wait_idle(3000);

    // Pointer wrap over 3*DEPTH words with random busy lengths
    $display("T5 wrap %0d words", 3 * DEPTH);
    base = pulse_bytes.size();
    sent.delete();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      guard = 0;
      while (!bus.word_ready && guard < 500) begin
        tick(1);
        guard++;
      end
      w = $urandom;
      busy_len = $urandom_range(1, 12);
      push(w);
      sent.push_back(w);
      tick($urandom_range(0, 6));
    end
    wait_idle(5000);
    chk("t5 frames", 32'(pulse_bytes.size() - base), 32'(3 * DEPTH * FRAMES));
    for (int i = 0; i < 3 * DEPTH; i++) begin
      for (int k = 0; k < FRAMES; k++) begin
        chk("t5 byte", 32'(pulse_bytes[base + i * FRAMES + k]), 32'(frame_byte(sent[i], k)));
      end
    end

    // Random traffic including refused pushes and a no-acknowledge stretch
    $display("T6 random traffic");
    for (int c = 0; c < 300; c++) begin
      bus.word_valid = 1'($urandom_range(0, 1));
      bus.word_in    = $urandom;
      busy_len       = $urandom_range(1, 12);
      if (c == 100) busy_mode = 2;
      if (c == 160) release_busy();
      tick(1);
    end
    bus.word_valid = 1'b0;
    wait_idle(6000);

    // Reset in the middle of a word
    $display("T7 reset mid-word");
    busy_len = 10;
    base = pulse_bytes.size();
    push(32'hDEADBEEF);
    wait_pulses(base + 2, 200);
    chk("t7 byte1", 32'(pulse_bytes[base + 1]), 32'hBE);
    rst_n = 1'b0;
    tick(2);
    chk("t7 tx_byte_valid", 32'(bus.tx_byte_valid), 32'd0);
    chk("t7 tx_byte", 32'(bus.tx_byte), 32'd0);
    chk("t7 fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("t7 overflow", 32'(bus.overflow), 32'd0);
    chk("t7 word_ready", 32'(bus.word_ready), 32'd0);
    chk("t7 idle", 32'(bus.idle), 32'd1);
    rst_n = 1'b1;
    n = pulse_bytes.size();
    tick(40);
    chk("t7 no more pulses", 32'(pulse_bytes.size()), 32'(n));
    w = 32'h87654321;
    push(w);
    wait_idle(400);
    n = pulse_bytes.size();
    for (int k = 0; k < FRAMES; k++) begin
      chk("t7 clean byte", 32'(pulse_bytes[n - FRAMES + k]), 32'(frame_byte(w, k)));
    end

`ifdef SERIALIZER_CHECKSUM_EN
    // Checksum frame follows the data bytes
    $display("T8 checksum 01020304");
    base = pulse_bytes.size();
    push(32'h01020304);
    wait_idle(400);
    chk("t8 frames", 32'(pulse_bytes.size() - base), 32'd5);
    chk("t8 byte0", 32'(pulse_bytes[base + 0]), 32'h04);
    chk("t8 byte1", 32'(pulse_bytes[base + 1]), 32'h03);
    chk("t8 byte2", 32'(pulse_bytes[base + 2]), 32'h02);
    chk("t8 byte3", 32'(pulse_bytes[base + 3]), 32'h01);
    chk("t8 checksum", 32'(pulse_bytes[base + 4]), 32'h04);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
